trap_ctrl: RTL and testbench

Machine-mode trap sequencer sitting between the exception/interrupt detection logic, the pipeline and the Machine CSR file. It accepts a synchronous exception, an interrupt or an MRET, flushes and drains the pipeline, issues a single atomic CSR update, then hands a PC redirect to the fetch stage with a valid/ack handshake. It turns trap entry and exit into one ordered, multi-cycle sequence with a single point of arbitration.

---
 rtl/trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes one request, flushes and drains the pipe, commits CSRs, redirects fetch.
// Latency: 4 cycles request-to-IDLE at minimum, plus 1 per DRAIN wait cycle and 1 per redirect ack wait cycle.
// Backpressure: requests seen while busy are dropped; the redirect is held stable until redir_ack.
module trap_ctrl #(
    parameter int PC_SZ    = 32,
    parameter int RSZ      = 32,
    parameter int DRAIN_TO = 15
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             exc_flag,
    input  logic [RSZ-1:0]   exc_cause,
    input  logic [RSZ-1:0]   exc_tval,
    input  logic [PC_SZ-1:0] exc_pc,
    input  logic             irq_flag,
    input  logic [RSZ-1:0]   irq_cause,
    input  logic [PC_SZ-1:0] irq_pc,
    input  logic             mret,
    input  logic [RSZ-1:0]   mtvec,
    input  logic [RSZ-1:0]   mepc,
    input  logic             mstatus_mie,
    input  logic             mstatus_mpie,
    input  logic [1:0]       cur_mode,
    input  logic             pipe_empty,
    input  logic             redir_ack,
    output logic             busy,
    output logic             flush,
    output logic             stall_fetch,
    output logic             csr_trap_wr,
    output logic             csr_ret_wr,
    output logic [RSZ-1:0]   csr_mepc,
    output logic [RSZ-1:0]   csr_mcause,
    output logic [RSZ-1:0]   csr_mtval,
    output logic             csr_mie,
    output logic             csr_mpie,
    output logic [1:0]       csr_mpp,
    output logic             redir_vld,
    output logic [PC_SZ-1:0] redir_pc,
    output logic             drain_err
);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_DRAIN, S_COMMIT, S_REDIRECT} state_t;
    typedef enum logic [1:0] {K_EXC, K_IRQ, K_RET} kind_t;

    localparam logic [RSZ-1:0] TOP_BIT = RSZ'(1) << (RSZ - 1);
    localparam logic [RSZ-1:0] LOW2    = RSZ'(3);

    state_t           state;
    kind_t            kind_q;
    logic [RSZ-1:0]   cause_q;
    logic [RSZ-1:0]   tval_q;
    logic [PC_SZ-1:0] pc_q;
    logic [7:0]       drain_cnt;

    logic [RSZ-1:0]   base;
    logic [RSZ-1:0]   vec_off;
    logic [PC_SZ-1:0] target;
    logic             drain_done;

    // Target is evaluated during COMMIT, so it sees the mtvec/mepc of that cycle.
    always_comb begin
        base       = mtvec & ~LOW2;
        vec_off    = {cause_q[RSZ-3:0], 2'b00};
        drain_done = pipe_empty || (drain_cnt == 8'(DRAIN_TO - 1));
        if (kind_q == K_RET)
            target = PC_SZ'(mepc & ~LOW2);
        else if (kind_q == K_IRQ && mtvec[1:0] == 2'b01)
            target = PC_SZ'(base + vec_off);
        else
            target = PC_SZ'(base);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= S_IDLE;
            kind_q      <= K_EXC;
            cause_q     <= '0;
            tval_q      <= '0;
            pc_q        <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            flush       <= 1'b0;
            stall_fetch <= 1'b0;
            csr_trap_wr <= 1'b0;
            csr_ret_wr  <= 1'b0;
            csr_mepc    <= '0;
            csr_mcause  <= '0;
            csr_mtval   <= '0;
            csr_mie     <= 1'b0;
            csr_mpie    <= 1'b0;
            csr_mpp     <= '0;
            redir_vld   <= 1'b0;
            redir_pc    <= '0;
            drain_err   <= 1'b0;
        end else begin
            // Strobes and their data only live for the single COMMIT cycle.
            flush       <= 1'b0;
            csr_trap_wr <= 1'b0;
            csr_ret_wr  <= 1'b0;
            csr_mepc    <= '0;
            csr_mcause  <= '0;
            csr_mtval   <= '0;
            csr_mie     <= 1'b0;
            csr_mpie    <= 1'b0;
            csr_mpp     <= '0;
            case (state)
                S_IDLE: begin
                    if (exc_flag || irq_flag || mret) begin
                        state       <= S_FLUSH;
                        busy        <= 1'b1;
                        flush       <= 1'b1;
                        stall_fetch <= 1'b1;
                        if (exc_flag) begin
                            kind_q  <= K_EXC;
                            cause_q <= exc_cause & ~TOP_BIT;
                            tval_q  <= exc_tval;
                            pc_q    <= exc_pc;
                        end else if (irq_flag) begin
                            kind_q  <= K_IRQ;
                            cause_q <= irq_cause | TOP_BIT;
                            tval_q  <= '0;
                            pc_q    <= irq_pc;
                        end else begin
                            kind_q  <= K_RET;
                            cause_q <= '0;
                            tval_q  <= '0;
                            pc_q    <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    state     <= S_DRAIN;
                    drain_cnt <= '0;
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_COMMIT;
                        if (!pipe_empty)
                            drain_err <= 1'b1;
                        if (kind_q == K_RET) begin
                            csr_ret_wr <= 1'b1;
                            csr_mie    <= mstatus_mpie;
                            csr_mpie   <= 1'b1;
                        end else begin
                            csr_trap_wr <= 1'b1;
                            csr_mepc    <= RSZ'(pc_q);
                            csr_mcause  <= cause_q;
                            csr_mtval   <= tval_q;
                            csr_mpie    <= mstatus_mie;
                            csr_mpp     <= cur_mode;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                S_COMMIT: begin
                    state     <= S_REDIRECT;
                    redir_vld <= 1'b1;
                    redir_pc  <= target;
                end
                S_REDIRECT: begin
                    if (redir_ack) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        stall_fetch <= 1'b0;
                        redir_vld   <= 1'b0;
                        redir_pc    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios from the trap rules plus randomized traffic against a reference model.
module tb_trap_ctrl;

    localparam int DRAIN_TO = 15;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        exc_flag, irq_flag, mret;
    logic [31:0] exc_cause, exc_tval, exc_pc, irq_cause, irq_pc, mtvec, mepc;
    logic        mstatus_mie, mstatus_mpie;
    logic [1:0]  cur_mode;
    logic        pipe_empty, redir_ack;
    logic        busy, flush, stall_fetch, csr_trap_wr, csr_ret_wr;
    logic [31:0] csr_mepc, csr_mcause, csr_mtval, redir_pc;
    logic        csr_mie, csr_mpie, redir_vld, drain_err;
    logic [1:0]  csr_mpp;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_err = 1'b0;

    trap_ctrl #(.PC_SZ(32), .RSZ(32), .DRAIN_TO(DRAIN_TO)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .exc_flag(exc_flag), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
        .irq_flag(irq_flag), .irq_cause(irq_cause), .irq_pc(irq_pc), .mret(mret),
        .mtvec(mtvec), .mepc(mepc), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
        .cur_mode(cur_mode), .pipe_empty(pipe_empty), .redir_ack(redir_ack),
        .busy(busy), .flush(flush), .stall_fetch(stall_fetch),
        .csr_trap_wr(csr_trap_wr), .csr_ret_wr(csr_ret_wr),
        .csr_mepc(csr_mepc), .csr_mcause(csr_mcause), .csr_mtval(csr_mtval),
        .csr_mie(csr_mie), .csr_mpie(csr_mpie), .csr_mpp(csr_mpp),
        .redir_vld(redir_vld), .redir_pc(redir_pc), .drain_err(drain_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int busy_cyc, flush_cyc, drain_cyc, trap_stb, ret_stb, vld_cyc, unstable, data_nz;
        bit done, first_flush, err;
        logic [31:0] mepc, mcause, mtval, pc;
        logic mie, mpie;
        logic [1:0] mpp;
    } obs_t;

    typedef struct {
        int kind;  // 0 exception, 1 interrupt, 2 mret
        logic [31:0] mepc, mcause, mtval, target;
        logic mie, mpie;
        logic [1:0] mpp;
    } exp_t;

    function automatic logic [138:0] all_outs();
        return {busy, flush, stall_fetch, csr_trap_wr, csr_ret_wr, csr_mepc, csr_mcause, csr_mtval,
                csr_mie, csr_mpie, csr_mpp, redir_vld, redir_pc, drain_err};
    endfunction

    // Expected trap outcome from the architectural rules, evaluated on the current inputs.
    function automatic exp_t model();
        exp_t e;
        e = '{default: 0};
        if (exc_flag) begin
            e.kind = 0; e.mepc = exc_pc; e.mcause = exc_cause & 32'h7FFF_FFFF; e.mtval = exc_tval;
        end else if (irq_flag) begin
            e.kind = 1; e.mepc = irq_pc; e.mcause = 32'h8000_0000 | irq_cause; e.mtval = 0;
        end else begin
            e.kind = 2;
        end
        if (e.kind == 2) begin
            e.mie = mstatus_mpie; e.mpie = 1'b1; e.mpp = 2'b00; e.target = mepc & ~32'd3;
        end else begin
            e.mie = 1'b0; e.mpie = mstatus_mie; e.mpp = cur_mode; e.target = mtvec & ~32'd3;
            if (e.kind == 1 && (mtvec % 4) == 1)
                e.target = e.target + (irq_cause % (1 << 30)) * 4;
        end
        return e;
    endfunction

    // Drives one sequence from request to return-to-idle and records what the DUT did each cycle.
    task automatic do_seq(input int pipe_wait, input int ack_wait, input bit hold, output obs_t o);
        o = '{default: 0};
        pipe_empty = 1'b0;
        redir_ack  = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk_in);
            if (cyc == 0) o.first_flush = flush;
            if (!hold) begin exc_flag = 0; irq_flag = 0; mret = 0; end
            if (!busy) begin o.done = (o.vld_cyc > 0); break; end
            o.busy_cyc++;
            if (flush) o.flush_cyc++;
            if (csr_trap_wr || csr_ret_wr) begin
                o.trap_stb += int'(csr_trap_wr); o.ret_stb += int'(csr_ret_wr);
                o.mepc = csr_mepc; o.mcause = csr_mcause; o.mtval = csr_mtval;
                o.mie = csr_mie; o.mpie = csr_mpie; o.mpp = csr_mpp;
            end else if ({csr_mepc, csr_mcause, csr_mtval, csr_mie, csr_mpie, csr_mpp} != '0) begin
                o.data_nz++;
            end
            if (stall_fetch && !flush && !redir_vld && !csr_trap_wr && !csr_ret_wr) begin
                o.drain_cyc++;
                pipe_empty = (o.drain_cyc > pipe_wait);
            end
            if (redir_vld) begin
                if (o.vld_cyc == 0) o.pc = redir_pc;
                else if (redir_pc !== o.pc) o.unstable++;
                o.vld_cyc++;
                redir_ack = (o.vld_cyc > ack_wait);
            end
        end
        exc_flag = 0; irq_flag = 0; mret = 0; redir_ack = 0; pipe_empty = 0;
        o.err = drain_err;
    endtask

    task automatic test_reset();
        reset_in = 0; exc_flag = 0; irq_flag = 0; mret = 0; pipe_empty = 0; redir_ack = 0;
        exc_cause = 0; exc_tval = 0; exc_pc = 0; irq_cause = 0; irq_pc = 0; mtvec = 0; mepc = 0;
        mstatus_mie = 0; mstatus_mpie = 0; cur_mode = 0;
        repeat (3) @(negedge clk_in);
        n_tests++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
        reset_in = 1;
        repeat (3) @(negedge clk_in);
        n_tests++; if (busy !== 1'b0 || stall_fetch !== 1'b0) begin n_fail++; $display("FAIL idle_no_request: busy %b stall %b want 0 0", busy, stall_fetch); end
        exp_err = 0;
    endtask

    task automatic test_exception();
        obs_t o;
        exc_flag = 1; exc_cause = 2; exc_pc = 32'h100; exc_tval = 32'h55; mtvec = 32'h8001;
        mstatus_mie = 1; mstatus_mpie = 0; cur_mode = 0;
        do_seq(0, 0, 0, o);
        n_tests++; if (!o.first_flush || o.flush_cyc != 1) begin n_fail++; $display("FAIL exc_flush: first %b cycles %0d want 1 1", o.first_flush, o.flush_cyc); end
        n_tests++; if (o.busy_cyc != 4 || !o.done) begin n_fail++; $display("FAIL exc_latency: busy cycles %0d done %b want 4 1", o.busy_cyc, o.done); end
        n_tests++; if (o.trap_stb != 1 || o.ret_stb != 0) begin n_fail++; $display("FAIL exc_strobes: trap %0d ret %0d want 1 0", o.trap_stb, o.ret_stb); end
        n_tests++; if (o.mepc !== 32'h100 || o.mcause !== 32'd2 || o.mtval !== 32'h55) begin n_fail++; $display("FAIL exc_csr_data: %h %h %h want 100 2 55", o.mepc, o.mcause, o.mtval); end
        n_tests++; if ({o.mpie, o.mie, o.mpp} !== 4'b1000) begin n_fail++; $display("FAIL exc_mstatus: %b want 1000", {o.mpie, o.mie, o.mpp}); end
        n_tests++; if (o.pc !== 32'h8000) begin n_fail++; $display("FAIL exc_redir_pc: got %h want 8000", o.pc); end
        n_tests++; if (o.data_nz != 0) begin n_fail++; $display("FAIL exc_data_idle_zero: %0d nonzero cycles want 0", o.data_nz); end
    endtask

    task automatic test_irq();
        obs_t o;
        irq_flag = 1; irq_cause = 7; irq_pc = 32'h444; mtvec = 32'h8001; mstatus_mie = 0; cur_mode = 3;
        do_seq(0, 0, 0, o);
        n_tests++; if (o.mcause !== 32'h8000_0007 || o.mtval !== 32'd0 || o.mepc !== 32'h444) begin n_fail++; $display("FAIL irq_csr_data: %h %h %h want 80000007 0 444", o.mcause, o.mtval, o.mepc); end
        n_tests++; if ({o.mpie, o.mie, o.mpp} !== 4'b0011) begin n_fail++; $display("FAIL irq_mstatus: %b want 0011", {o.mpie, o.mie, o.mpp}); end
        n_tests++; if (o.pc !== 32'h801C) begin n_fail++; $display("FAIL irq_vectored_pc: got %h want 801c", o.pc); end
        irq_flag = 1; irq_cause = 7; mtvec = 32'h8000;
        do_seq(0, 0, 0, o);
        n_tests++; if (o.pc !== 32'h8000) begin n_fail++; $display("FAIL irq_direct_pc: got %h want 8000", o.pc); end
    endtask

    task automatic test_priority();
        obs_t o;
        exc_flag = 1; irq_flag = 1; mret = 1; exc_cause = 32'h8000_0005; exc_pc = 32'h200;
        irq_cause = 3; mtvec = 32'h4001; mepc = 32'h900;
        do_seq(0, 1, 1, o);
        n_tests++; if (o.trap_stb != 1 || o.ret_stb != 0) begin n_fail++; $display("FAIL prio_strobes: trap %0d ret %0d want 1 0", o.trap_stb, o.ret_stb); end
        n_tests++; if (o.mcause !== 32'd5 || o.mepc !== 32'h200 || o.pc !== 32'h4000) begin n_fail++; $display("FAIL prio_exc_wins: %h %h %h want 5 200 4000", o.mcause, o.mepc, o.pc); end
        repeat (3) @(negedge clk_in);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_dropped: busy %b want 0", busy); end
    endtask

    task automatic test_mret();
        obs_t o;
        mret = 1; mepc = 32'h2003; mstatus_mpie = 1; mstatus_mie = 0; cur_mode = 3;
        do_seq(0, 0, 0, o);
        n_tests++; if (o.ret_stb != 1 || o.trap_stb != 0) begin n_fail++; $display("FAIL mret_strobes: ret %0d trap %0d want 1 0", o.ret_stb, o.trap_stb); end
        n_tests++; if ({o.mie, o.mpie, o.mpp} !== 4'b1100) begin n_fail++; $display("FAIL mret_mstatus: %b want 1100", {o.mie, o.mpie, o.mpp}); end
        n_tests++; if (o.pc !== 32'h2000) begin n_fail++; $display("FAIL mret_redir_pc: got %h want 2000", o.pc); end
    endtask

    task automatic test_drain_timeout();
        obs_t o;
        exc_flag = 1; exc_cause = 4; mtvec = 32'h100;
        do_seq(DRAIN_TO - 1, 0, 0, o);
        n_tests++; if (o.drain_cyc != DRAIN_TO || o.err) begin n_fail++; $display("FAIL drain_edge_no_timeout: cycles %0d err %b want %0d 0", o.drain_cyc, o.err, DRAIN_TO); end
        exc_flag = 1;
        do_seq(100000, 5, 0, o);
        n_tests++; if (o.drain_cyc != DRAIN_TO || !o.err) begin n_fail++; $display("FAIL drain_timeout: cycles %0d err %b want %0d 1", o.drain_cyc, o.err, DRAIN_TO); end
        n_tests++; if (o.vld_cyc != 6 || o.unstable != 0 || o.pc !== 32'h100) begin n_fail++; $display("FAIL redir_hold: vld %0d unstable %0d pc %h want 6 0 100", o.vld_cyc, o.unstable, o.pc); end
        irq_flag = 1; irq_cause = 1;
        do_seq(0, 0, 0, o);
        n_tests++; if (!o.err || o.drain_cyc != 1) begin n_fail++; $display("FAIL drain_err_sticky: err %b cycles %0d want 1 1", o.err, o.drain_cyc); end
        exp_err = 1;
    endtask

    task automatic test_reset_midflight();
        obs_t o;
        exc_flag = 1; exc_cause = 6; exc_pc = 32'h300; pipe_empty = 0;
        @(negedge clk_in); exc_flag = 0;
        repeat (2) @(negedge clk_in);
        #2 reset_in = 0;
        #1;
        n_tests++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_in_drain: got %h want 0", all_outs()); end
        @(negedge clk_in); reset_in = 1;
        mret = 1; mepc = 32'h700; pipe_empty = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in); mret = 0;
            if (redir_vld) break;
        end
        n_tests++; if (redir_vld !== 1'b1) begin n_fail++; $display("FAIL reach_redirect: redir_vld %b want 1", redir_vld); end
        #2 reset_in = 0;
        #1;
        n_tests++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_in_redirect: got %h want 0", all_outs()); end
        @(negedge clk_in); reset_in = 1; pipe_empty = 0;
        exp_err = 0;
        exc_flag = 1; exc_cause = 3; exc_pc = 32'h500; mtvec = 32'hA000;
        do_seq(2, 1, 0, o);
        n_tests++; if (o.err || o.pc !== 32'hA000 || o.mepc !== 32'h500 || !o.done) begin n_fail++; $display("FAIL after_reset_seq: err %b pc %h mepc %h done %b want 0 a000 500 1", o.err, o.pc, o.mepc, o.done); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        int pw, aw, exp_drain;
        logic [2:0] req;
        for (int it = 0; it < 40; it++) begin
            req = 3'($urandom_range(1, 7));
            exc_flag = req[0]; irq_flag = req[1]; mret = req[2];
            exc_cause = $urandom; exc_tval = $urandom; exc_pc = $urandom;
            irq_cause = $urandom; irq_pc = $urandom;
            mtvec = ($urandom & ~32'd3) | 32'($urandom_range(0, 3));
            mepc = $urandom; mstatus_mie = 1'($urandom); mstatus_mpie = 1'($urandom);
            cur_mode = 2'($urandom);
            pw = $urandom_range(0, DRAIN_TO + 2); aw = $urandom_range(0, 3);
            e = model();
            exp_drain = (pw + 1 < DRAIN_TO) ? pw + 1 : DRAIN_TO;
            if (pw >= DRAIN_TO) exp_err = 1;
            do_seq(pw, aw, 0, o);
            n_tests++; if (!o.done || o.flush_cyc != 1 || o.drain_cyc != exp_drain || o.vld_cyc != aw + 1 || o.busy_cyc != 2 + exp_drain + aw + 1) begin
                n_fail++; $display("FAIL rnd%0d_timing: done %b flush %0d drain %0d vld %0d busy %0d want 1 1 %0d %0d %0d", it, o.done, o.flush_cyc, o.drain_cyc, o.vld_cyc, o.busy_cyc, exp_drain, aw + 1, 3 + exp_drain + aw); end
            n_tests++; if (o.trap_stb != int'(e.kind != 2) || o.ret_stb != int'(e.kind == 2)) begin n_fail++; $display("FAIL rnd%0d_strobes: trap %0d ret %0d kind %0d", it, o.trap_stb, o.ret_stb, e.kind); end
            n_tests++; if (e.kind != 2 && {o.mepc, o.mcause, o.mtval} !== {e.mepc, e.mcause, e.mtval}) begin n_fail++; $display("FAIL rnd%0d_csr_data: %h %h %h want %h %h %h", it, o.mepc, o.mcause, o.mtval, e.mepc, e.mcause, e.mtval); end
            n_tests++; if ({o.mie, o.mpie, o.mpp} !== {e.mie, e.mpie, e.mpp}) begin n_fail++; $display("FAIL rnd%0d_mstatus: %b want %b", it, {o.mie, o.mpie, o.mpp}, {e.mie, e.mpie, e.mpp}); end
            n_tests++; if (o.pc !== e.target || o.unstable != 0) begin n_fail++; $display("FAIL rnd%0d_redir: pc %h unstable %0d want %h 0", it, o.pc, o.unstable, e.target); end
            n_tests++; if (o.err !== exp_err || o.data_nz != 0) begin n_fail++; $display("FAIL rnd%0d_err_data: err %b nz %0d want %b 0", it, o.err, o.data_nz, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_irq();
        test_priority();
        test_mret();
        test_drain_timeout();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
